// File: rtl/calc_core_p.sv
// Key-locked ALU with a register file and a serial MSB-first readout port.
// One FSM (LOCKED -> IDLE <-> SHIFT) owns every register and output.
module calc_core_p #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 4,
  parameter int DIV_W      = 8,
  parameter int KEY_PULSES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InputKey,
  input  logic              ValidCmd,
  input  logic              RW,
  input  logic [WIDTH-1:0]  InA,
  input  logic [WIDTH-1:0]  InB,
  input  logic [3:0]        Sel,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DIV_W-1:0]  ConfigDiv,
  output logic              Unlocked,
  output logic              Busy,
  output logic              DOut,
  output logic              DOutValid,
  output logic              Err
);

  localparam int RES_W = 2 * WIDTH;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int KEY_W = $clog2(KEY_PULSES + 1);
  localparam int BIT_W = $clog2(RES_W);

  typedef enum logic [1:0] {LOCKED, IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [KEY_W-1:0] key_cnt_q;
  logic             key_prev_q;
  logic [RES_W-1:0] mem_q [DEPTH];
  logic [RES_W-1:0] shift_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic             unlocked_q;
  logic             busy_q;
  logic             dout_q;
  logic             dvalid_q;
  logic             err_q;

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;
  logic [RES_W-1:0] alu_d;
  logic             alu_ok;
  logic [RES_W-1:0] rd_data;

  assign a_ext   = RES_W'(InA);
  assign b_ext   = RES_W'(InB);
  assign rd_data = mem_q[Addr];

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_d  = '0;
    alu_ok = 1'b1;
    case (Sel)
      4'd0:    alu_d = a_ext + b_ext;
      4'd1:    alu_d = a_ext - b_ext;
      4'd2:    alu_d = a_ext * b_ext;
      4'd3:    alu_d = a_ext & b_ext;
      4'd4:    alu_d = a_ext | b_ext;
      4'd5:    alu_d = a_ext ^ b_ext;
      4'd6:    alu_d = a_ext << InB[3:0];
      4'd7:    alu_d = a_ext >> InB[3:0];
      4'd8:    alu_d = {{(RES_W-3){1'b0}}, (InA > InB), (InA == InB), (InA < InB)};
      default: alu_ok = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= LOCKED;
      key_cnt_q  <= '0;
      key_prev_q <= 1'b1;
      shift_q    <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      unlocked_q <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= 1'b0;
      dvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: the register file is cleared by reset because a read after reset must return zero.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      key_prev_q <= InputKey;
      err_q      <= 1'b0;
      case (state_q)
        LOCKED: begin
          if (key_cnt_q == KEY_W'(KEY_PULSES)) begin
            state_q    <= IDLE;
            unlocked_q <= 1'b1;
          end else if (InputKey && !key_prev_q) begin
            key_cnt_q <= key_cnt_q + KEY_W'(1);
          end
        end
        IDLE: begin
          if (ValidCmd && RW) begin
            if (alu_ok) mem_q[Addr] <= alu_d;
            else        err_q       <= 1'b1;
          end else if (ValidCmd) begin
            // First bit goes out on the accept edge so DOutValid spans exactly 2*WIDTH periods.
            shift_q  <= rd_data;
            div_q    <= ConfigDiv;
            cnt_q    <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b1;
            dvalid_q <= 1'b1;
            dout_q   <= rd_data[RES_W-1];
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == div_q) begin
            cnt_q <= '0;
            if (bit_q == BIT_W'(RES_W - 1)) begin
              busy_q   <= 1'b0;
              dvalid_q <= 1'b0;
              dout_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              shift_q <= shift_q << 1;
              dout_q  <= shift_q[RES_W-2];
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= LOCKED;
      endcase
    end
  end

  assign Unlocked  = unlocked_q;
  assign Busy      = busy_q;
  assign DOut      = dout_q;
  assign DOutValid = dvalid_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_calc_core_p.sv
// Directed bench for calc_core_p: unlock, ALU writes, serial reads, error, reset abort.
// Expected values are hand-computed constants.
module tb_calc_core_p;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        InputKey = 1'b1;
  logic        ValidCmd = 1'b0;
  logic        RW = 1'b0;
  logic [7:0]  InA = '0;
  logic [7:0]  InB = '0;
  logic [3:0]  Sel = '0;
  logic [3:0]  Addr = '0;
  logic [7:0]  ConfigDiv = '0;
  logic        Unlocked, Busy, DOut, DOutValid, Err;

  int total = 0;
  int bad   = 0;

  calc_core_p #(.WIDTH(8), .ADDR_W(4), .DIV_W(8), .KEY_PULSES(2)) dut (
    .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd), .RW(RW),
    .InA(InA), .InB(InB), .Sel(Sel), .Addr(Addr), .ConfigDiv(ConfigDiv),
    .Unlocked(Unlocked), .Busy(Busy), .DOut(DOut), .DOutValid(DOutValid), .Err(Err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two key pulses at 8-cycle spacing; Unlocked must rise one cycle after the second rising edge.
  task automatic do_unlock();
    InputKey = 1'b0; repeat (8) tick();
    InputKey = 1'b1; repeat (8) tick();
    check("single_pulse_locked", {31'd0, Unlocked}, 32'd0);
    InputKey = 1'b0; repeat (8) tick();
    InputKey = 1'b1; tick();
    check("unlock_at_edge", {31'd0, Unlocked}, 32'd0);
    tick();
    check("unlock_next_cycle", {31'd0, Unlocked}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] s, input logic [3:0] ad);
    ValidCmd = 1'b1; RW = 1'b1; InA = a; InB = b; Sel = s; Addr = ad;
    tick();
    ValidCmd = 1'b0;
  endtask

  // Issues a read and collects the serial word; at cycle 'inject' a write and a read are
  // attempted (and ConfigDiv changed), all of which must be ignored.
  task automatic rd_check(input string tag, input logic [3:0] ad, input logic [7:0] div,
                          input logic [15:0] exp, input int inject);
    logic [15:0] val;
    logic        cur;
    int          ncyc;
    bit          stable;
    val = '0; cur = 1'b0; ncyc = 0; stable = 1'b1;
    ValidCmd = 1'b1; RW = 1'b0; Addr = ad; ConfigDiv = div;
    tick();
    ValidCmd = 1'b0;
    while (DOutValid === 1'b1 && ncyc < 2000) begin
      if (ncyc % (int'(div) + 1) == 0) begin
        val = {val[14:0], DOut};
        cur = DOut;
      end else if (DOut !== cur) begin
        stable = 1'b0;
      end
      check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      ValidCmd = 1'b0;
      if (ncyc == inject) begin
        ValidCmd = 1'b1; RW = 1'b1; Sel = 4'd0; InA = 8'd0; InB = 8'd0; Addr = ad;
        ConfigDiv = 8'd0;
      end else if (ncyc == inject + 1) begin
        ValidCmd = 1'b1; RW = 1'b0;
      end
      tick();
      ncyc++;
    end
    ValidCmd = 1'b0;
    check({tag, "_data"}, {16'd0, val}, {16'd0, exp});
    check({tag, "_cycles"}, ncyc, 16 * (int'(div) + 1));
    check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_dout_idle"}, {31'd0, DOut}, 32'd0);
    tick();
    check({tag, "_no_requeue"}, {30'd0, Busy, DOutValid}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {27'd0, Unlocked, Busy, DOut, DOutValid, Err}, 32'd0);
    Reset = 1'b1;
    tick();

    // Commands while locked are ignored.
    do_write(8'h11, 8'h22, 4'd0, 4'd9);
    check("locked_no_err", {31'd0, Err}, 32'd0);
    do_unlock();
    rd_check("locked_write_ignored", 4'd9, 8'd0, 16'h0000, -1);

    do_write(8'h01, 8'h05, 4'd0, 4'd0);
    rd_check("add_div1", 4'd0, 8'd1, 16'h0006, -1);

    do_write(8'hFF, 8'hFF, 4'd2, 4'd1);
    rd_check("mul_ff", 4'd1, 8'd0, 16'hFE01, -1);
    do_write(8'h00, 8'h01, 4'd1, 4'd2);
    rd_check("sub_wrap", 4'd2, 8'd0, 16'hFFFF, -1);
    do_write(8'hF0, 8'h3C, 4'd3, 4'd3);
    rd_check("and", 4'd3, 8'd0, 16'h0030, -1);
    do_write(8'h81, 8'h04, 4'd6, 4'd4);
    rd_check("shl", 4'd4, 8'd0, 16'h0810, -1);
    do_write(8'h05, 8'h03, 4'd8, 4'd5);
    rd_check("cmp_gt", 4'd5, 8'd0, 16'h0004, -1);
    do_write(8'h80, 8'h03, 4'd7, 4'd6);
    rd_check("shr", 4'd6, 8'd0, 16'h0010, -1);
    do_write(8'hAA, 8'h0F, 4'd5, 4'd7);
    rd_check("xor", 4'd7, 8'd0, 16'h00A5, -1);
    do_write(8'h12, 8'h34, 4'd4, 4'd8);
    rd_check("or", 4'd8, 8'd0, 16'h0036, -1);

    // Unsupported select: one-cycle Err, target untouched.
    do_write(8'h07, 8'h07, 4'd12, 4'd0);
    check("err_pulse", {31'd0, Err}, 32'd1);
    tick();
    check("err_one_cycle", {31'd0, Err}, 32'd0);
    rd_check("err_no_write", 4'd0, 8'd0, 16'h0006, -1);

    // Write and read attempts plus ConfigDiv change during SHIFT are ignored.
    rd_check("shift_ignore", 4'd1, 8'd2, 16'hFE01, 7);
    rd_check("shift_mem_kept", 4'd1, 8'd0, 16'hFE01, -1);

    // Reset in the middle of a transfer (bit 5 of 0x0006, one cycle per bit).
    ValidCmd = 1'b1; RW = 1'b0; Addr = 4'd0; ConfigDiv = 8'd0;
    tick();
    ValidCmd = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b0;
    tick();
    check("midshift_rst_outputs", {28'd0, Busy, DOutValid, DOut, Unlocked}, 32'd0);
    Reset = 1'b1;
    repeat (4) tick();
    check("after_rst_quiet", {29'd0, Busy, DOutValid, DOut}, 32'd0);
    do_unlock();
    rd_check("mem_cleared", 4'd0, 8'd0, 16'h0000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
